// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexing scan controller for DIGITS common-anode digits that share
//   one 4-bit-to-7-segment decoder. Each digit gets BLANK_CYCLES dark cycles
//   (anti-ghosting), then TICK_DIV lit cycles. New values come in through a
//   valid/ready handshake into a shadow register. They are copied to the
//   displayed register only at a frame boundary, or at once while the scan is
//   disabled, so a frame never mixes old and new digits.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_en           scan enable; low = dark, scan parked at frame start
//   i_load_data    new value, nibble k -> digit k
//   i_load_valid   i_load_data valid
//   o_load_ready   no update pending (combinational)
//   o_dec_a        nibble to the shared decoder
//   o_an           active-low digit enables, at most one low
//   o_frame_done   one-cycle pulse in the first cycle of each new frame
module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_load_data,
  input  logic                  i_load_valid,
  output logic                  o_load_ready,
  output logic [3:0]            o_dec_a,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame_done
);

  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [4*DIGITS-1:0]   r_active, r_shadow, w_active_nxt;
  logic                  r_pending;
  logic [DIGITS-1:0]     r_an, w_an_nxt;
  logic [3:0]            r_dec_a, w_dec_nxt;
  logic                  r_frame_done;
  logic                  w_frame_end, w_accept, w_commit;

  assign o_load_ready = ~r_pending;
  assign o_an         = r_an;
  assign o_dec_a      = r_dec_a;
  assign o_frame_done = r_frame_done;

  // A load can only be accepted while nothing is pending, so accept and
  // commit never collide on the same edge.
  assign w_accept = i_load_valid & ~r_pending;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_frame_end = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_BLANK;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = S_SHOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt   = '0;
              w_frame_end = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = S_BLANK;
      endcase
    end
  end

  // With the scan disabled no frame is in progress, so a pending value can
  // be committed immediately.
  assign w_commit     = r_pending & (w_frame_end | ~i_en);
  assign w_active_nxt = w_commit ? r_shadow : r_active;

  // Outputs are registered from next-state values so they line up with the
  // state they describe. dec_a follows the next digit index; it can only
  // change on BLANK entry or on a commit, never while a digit is lit.
  always_comb begin
    w_an_nxt  = '1;
    w_dec_nxt = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_idx_nxt == IW'(k)) begin
        w_dec_nxt = w_active_nxt[4*k +: 4];
        if (w_state_nxt == S_SHOW) w_an_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_BLANK;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_active     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_an         <= '1;
      r_dec_a      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active     <= w_active_nxt;
      if (w_accept) r_shadow <= i_load_data;
      r_pending    <= w_accept | (r_pending & ~w_commit);
      r_an         <= w_an_nxt;
      r_dec_a      <= w_dec_nxt;
      r_frame_done <= w_frame_end;
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller that shares one 4-bit-to-7-segment decoder among several common-anode digits. Holds a displayed value, presents one nibble per digit to the decoder's 4-bit input, and drives active-low digit enables with an anti-ghosting blank gap between digits. Downstream logic loads new values through a valid/ready handshake; updates take effect only at frame boundaries, so no frame mixes old and new digits.

## Interface
- DIGITS, 4: number of multiplexed digits, 1..8
- TICK_DIV, 50000: clock cycles each digit is lit (SHOW), >= 1
- BLANK_CYCLES, 2: clock cycles all digits are dark before each digit (BLANK), >= 1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable; low = all digits dark, scan held at start of frame
- load_data  in  4*DIGITS  new display value; nibble k (bits 4k+3:4k) goes to digit k
- load_valid  in  1  load_data valid
- load_ready  out  1  controller can accept a load (= no update pending)
- dec_a  out  4  nibble to decoder input A[3:0]
- an  out  DIGITS  digit enables, active-low, at most one bit low at any time
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: active[4*DIGITS-1:0], shadow[4*DIGITS-1:0], pending, digit index idx, phase counter cnt, state {BLANK, SHOW}.
- Reset (rst high at edge): state=BLANK, idx=0, cnt=0, active=0, shadow=0, pending=0, an=all 1s, dec_a=0, frame_done=0. load_ready=1 in the first cycle after reset.
- load_ready = ~pending (combinational). Accept when load_valid && load_ready: shadow<=load_data, pending<=1. load_data ignored when not accepted.
- BLANK: an=all 1s, dec_a=active nibble idx. After BLANK_CYCLES cycles -> SHOW, cnt cleared.
- SHOW: an[idx]=0, others 1; dec_a unchanged. After TICK_DIV cycles: if idx<DIGITS-1, idx<=idx+1 -> BLANK; else frame boundary.
- Frame boundary (last SHOW cycle of digit DIGITS-1 completes): idx<=0, state<=BLANK, frame_done pulses in the next cycle. If pending: active<=shadow, pending<=0, and dec_a is loaded from shadow[3:0] on the same edge (new frame shows new data from its first cycle).
- en low: state forced BLANK, idx=0, cnt=0, an=all 1s, frame_done=0; a pending update commits on the next edge (no frame in progress), dec_a<=new nibble 0. en rising restarts a full frame from digit 0 BLANK.
- Simultaneous load accept and frame boundary: impossible, load_ready=0 whenever pending; if no pending at boundary, an accept on that edge is committed at the following boundary.
- rst mid-frame: immediate return to reset state; pending update discarded.
- Counters sized to $clog2 of their maxima; no wrap beyond DIGITS-1 or TICK_DIV-1.

## Timing
- All outputs registered except load_ready.
- Digit period = BLANK_CYCLES + TICK_DIV cycles; frame = DIGITS * digit period.
- After rst deasserts with en=1: BLANK_CYCLES cycles an=all 1s, then an[0]=0 for TICK_DIV cycles.
- dec_a changes only on BLANK entry (or commit), never while any an bit is low.
- Load-to-display latency: from accept to next frame boundary, at most one frame + 1 cycle.
- load_ready returns to 1 the cycle after commit.

## Test plan
- Reset, DIGITS=4, TICK_DIV=3, BLANK_CYCLES=1, en=1, no load -> dec_a=0, an sequence per 16-cycle frame: 1111,1110×3,1111,1101×3,1111,1011×3,1111,0111×3; frame_done every 16 cycles.
- Load 16'h1234 mid-frame -> load_ready drops next cycle; current frame continues old nibbles; after boundary digits show 4,3,2,1 (dec_a 4 with an=1110), load_ready=1.
- Second load_valid while pending -> not accepted, shadow unchanged; after commit, held load_valid accepted.
- en low during SHOW of digit 2 -> an=1111 next cycle, idx=0; en high -> frame restarts with 1-cycle blank then an=1110.
- Pending load with en=0 -> committed next edge, dec_a=new nibble 0.
- rst asserted mid-frame with pending load -> an=1111, dec_a=0, active=0, load_ready=1, pending update lost.
